// File: rtl/fifo_sync_flags_pkg.sv
// Shared definitions for fifo_sync_flags: depth/count-width helpers, default
// thresholds and the per-edge operation encoding.
package fifo_sync_flags_pkg;

    localparam int unsigned DEF_AE_TH = 2;

    // Encoded as {wr_ok, rd_ok}
    typedef enum logic [1:0] {
        OpHold  = 2'b00,
        OpRead  = 2'b01,
        OpWrite = 2'b10,
        OpBoth  = 2'b11
    } fifo_op_e;

    function automatic int unsigned fifo_depth(input int unsigned w);
        return 32'd1 << w;
    endfunction

    function automatic int unsigned def_af_th(input int unsigned w);
        return fifo_depth(w) - 32'd2;
    endfunction

    // One extra bit so a full queue (2**W words) is representable.
    function automatic int unsigned count_width(input int unsigned w);
        return w + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// 2**W x B storage: synchronous write port, asynchronous read port.
module fifo_regfile
    import fifo_sync_flags_pkg::*;
#(
    parameter int unsigned B = 8,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr,
    output logic [B-1:0] rdata
);
    localparam int unsigned DEPTH = fifo_depth(W);

    logic [B-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Synchronous show-ahead FIFO with occupancy count and registered threshold flags.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_sync_flags
    import fifo_sync_flags_pkg::*;
#(
    parameter int unsigned B     = 8,
    parameter int unsigned W     = 4,
    parameter int unsigned AF_TH = def_af_th(W),
    parameter int unsigned AE_TH = DEF_AE_TH
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      wr,
    input  logic                      rd,
    input  logic [B-1:0]              w_data,
    output logic [B-1:0]              r_data,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_empty,
    output logic                      almost_full,
    output logic [count_width(W)-1:0] count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);
    localparam int unsigned   CW      = count_width(W);
    localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth(W));
    localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_TH);

    logic [W-1:0]  w_ptr_q, w_ptr_d;
    logic [W-1:0]  r_ptr_q, r_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q, ae_q, af_q;
    logic          wr_ok, rd_ok;
    fifo_op_e      op;

    // A write to a full queue is only accepted alongside a read that frees a slot.
    assign wr_ok = wr & (~full_q | rd);
    assign rd_ok = rd & ~empty_q;
    assign op    = fifo_op_e'({wr_ok, rd_ok});

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        unique case (op)
            OpWrite: begin
                w_ptr_d = w_ptr_q + W'(1);
                count_d = count_q + CW'(1);
            end
            OpRead: begin
                r_ptr_d = r_ptr_q + W'(1);
                count_d = count_q - CW'(1);
            end
            OpBoth: begin
                w_ptr_d = w_ptr_q + W'(1);
                r_ptr_d = r_ptr_q + W'(1);
            end
            OpHold: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= (AF_TH == 0);
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DEPTH_C);
            ae_q    <= (count_d <= AE_C);
            af_q    <= (count_d >= AF_C);
        end
    end

    fifo_regfile #(
        .B(B),
        .W(W)
    ) u_regfile (
        .clk  (CLK),
        .we   (wr_ok),
        .waddr(w_ptr_q),
        .wdata(w_data),
        .raddr(r_ptr_q),
        .rdata(r_data)
    );

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    // A new error on the same edge as clr_err takes priority over the clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr & full_q & ~rd) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (rd & empty_q) begin
                unf_q <= 1'b1;
            end else if (clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Randomised and directed bench for fifo_sync_flags against a queue-based model.
// Error-flag expectations follow FIFO_ERR_FLAGS_EN as seen by this file.
module tb_fifo_sync_flags;
    localparam int B     = 8;
    localparam int W     = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         CLK, RESET_N, wr, rd, clr_err;
    logic [B-1:0] w_data, r_data;
    logic         empty, full, almost_empty, almost_full, overflow, underflow;
    logic [W:0]   count;

    int           n_total = 0;
    int           n_bad   = 0;
    logic [B-1:0] model_q[$];
    bit           m_ovf, m_unf;

    fifo_sync_flags #(
        .B(B),
        .W(W),
        .AF_TH(AF),
        .AE_TH(AE)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .wr          (wr),
        .rd          (rd),
        .w_data      (w_data),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        n = model_q.size();
        check_eq("count", 32'(count), 32'(n));
        check_eq("empty", 32'(empty), 32'(n == 0));
        check_eq("full", 32'(full), 32'(n == DEPTH));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check_eq("almost_full", 32'(almost_full), 32'(n >= AF));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("underflow", 32'(underflow), 32'(m_unf));
        if (n != 0) check_eq("r_data", 32'(r_data), 32'(model_q[0]));
    endtask

    task automatic cycle(input bit w, input bit r, input logic [B-1:0] d, input bit c);
        bit full_m, empty_m;
        @(negedge CLK);
        wr = w; rd = r; w_data = d; clr_err = c;
        @(posedge CLK);
        full_m  = (model_q.size() == DEPTH);
        empty_m = (model_q.size() == 0);
        if (ERR_EN) begin
            if (w && full_m && !r) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            if (r && empty_m) m_unf = 1'b1;
            else if (c) m_unf = 1'b0;
        end
        if (r && !empty_m) void'(model_q.pop_front());
        if (w && (!full_m || r)) model_q.push_back(d);
        #1 check_state();
    endtask

    initial begin
        CLK = 1'b0; RESET_N = 1'b0; wr = 1'b0; rd = 1'b0; w_data = '0; clr_err = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        #12 check_state();
        @(negedge CLK) RESET_N = 1'b1;

        // Fill to full, then a dropped write while full.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hA1 + 8'(i), 1'b0);
        check_eq("fill_head", 32'(r_data), 32'hA1);
        check_eq("fill_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b0, 8'hFF, 1'b0);
        check_eq("ovf_set", 32'(overflow), 32'(ERR_EN));
        check_eq("ovf_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("drained_empty", 32'(empty), 32'd1);

        // Simultaneous read/write at full.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hA1 + 8'(i), 1'b0);
        cycle(1'b1, 1'b1, 8'hB5, 1'b0);
        check_eq("full_rw_head", 32'(r_data), 32'hA2);
        check_eq("full_rw_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

        // Simultaneous read/write at empty, then clear errors.
        cycle(1'b1, 1'b1, 8'hC7, 1'b0);
        check_eq("empty_rw_head", 32'(r_data), 32'hC7);
        check_eq("unf_set", 32'(underflow), 32'(ERR_EN));
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("unf_clr", 32'(underflow), 32'd0);
        check_eq("ovf_clr", 32'(overflow), 32'd0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);

        // Alternating write/read across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
            check_eq("wrap_word", 32'(r_data), 32'h10 + 32'(i));
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            check_eq("wrap_cnt", 32'(count <= 1), 32'd1);
        end

        // Random traffic with phases biased toward filling and draining.
        for (int i = 0; i < 400; i++) begin
            int pw;
            bit w, r, c;
            pw = ((i / 40) % 2 == 0) ? 75 : 25;
            w = ($urandom_range(0, 99) < pw);
            r = ($urandom_range(0, 99) < (100 - pw));
            c = ($urandom_range(0, 99) < 8);
            cycle(w, r, 8'($urandom), c);
        end

        // Asynchronous reset mid-cycle with words queued.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
        @(posedge CLK);
        #3 RESET_N = 1'b0;
        #1;
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_count", 32'(count), 32'd0);
        check_state();
        @(negedge CLK);
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        RESET_N = 1'b1;
        cycle(1'b1, 1'b0, 8'h55, 1'b0);
        check_eq("post_rst_head", 32'(r_data), 32'h55);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised synchronous show-ahead FIFO. Successor to the UART RX/TX buffer. Adds:
- occupancy count and programmable almost-full/almost-empty flags, for UART flow control and burst draining.
- defined behaviour for simultaneous read/write at the full and empty boundaries.
- optional sticky overflow/underflow error flags.
Sits between the UART rx/tx cores and the interface/ALU-control FSM.

Parameters:
B, 8, data word width in bits
W, 4, address width; depth = 2**W entries
AF_TH, 2**W-2, almost_full asserted when count >= AF_TH (range 1..2**W)
AE_TH, 2, almost_empty asserted when count <= AE_TH (range 0..2**W-1)

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET_N  in  1  asynchronous active-low reset
wr  in  1  write request, qualified internally by full
rd  in  1  read/acknowledge request, qualified internally by empty
w_data  in  B  write data
r_data  out  B  head-of-queue data (show-ahead, combinational from storage at read pointer)
empty  out  1  registered, queue holds 0 words
full  out  1  registered, queue holds 2**W words
almost_empty  out  1  registered, count <= AE_TH
almost_full  out  1  registered, count >= AF_TH
count  out  W+1  registered occupancy, 0..2**W
overflow  out  1  sticky: write attempted while full (see Optional Feature)
underflow  out  1  sticky: read attempted while empty (see Optional Feature)
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (RESET_N low, async):
  - pointers = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = (AF_TH == 0 ? 1 : 0).
  - overflow = 0, underflow = 0.
  - Storage contents are not reset.
- wr_ok = wr & (~full | rd): a write to a full FIFO is accepted only together with a read.
- rd_ok = rd & ~empty.
- Per edge, by {wr_ok, rd_ok}:
  - 10: mem[w_ptr] <= w_data; w_ptr++; count++.
  - 01: r_ptr++; count--.
  - 11: both pointers ++, count unchanged. On full, the head word is consumed while the write lands in the freed slot.
  - 00: hold.
- Empty with wr=1, rd=1: write only, rd ignored, counts as underflow. Never advances r_ptr past w_ptr.
- Full with wr=1, rd=0: write dropped, no state change, counts as overflow.
- Pointers wrap modulo 2**W, natural W-bit roll-over. count is W+1 bits and never wraps.
- All flags are computed from next-count and registered:
  - empty = (count_next == 0); full = (count_next == 2**W).
  - almost_empty / almost_full compare count_next against AE_TH / AF_TH.
- Latency:
  - A word written at edge k is visible on r_data, with empty low, after edge k.
  - A read at edge k presents the next word on r_data after edge k.
- r_data while empty is don't-care; the bench must not check it.
- RESET_N asserted mid-stream discards all queued words immediately. The first write after release lands at address 0.

Optional Feature:
FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow is set on any edge with wr & full & ~rd.
  - underflow is set on any edge with rd & empty.
  - Both hold until clr_err=1 at an edge or reset.
  - If clr_err and a new error occur on the same edge, set wins.
- Undefined: overflow and underflow are tied 0, clr_err is ignored, and no error logic is synthesised. Ports remain for a stable interface.

Decomposition:
- Shared header fifo_defs.vh:
  - depth macro/function (2**W)
  - default threshold constants
  - localparam for the count width (W+1)
- One natural sub-module, fifo_regfile: 2**W x B storage with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata).
- Control, pointers, count and flags stay in fifo_sync_flags.

Test Plan (B=8, W=2 so depth 4, AF_TH=3, AE_TH=1, FIFO_ERR_FLAGS_EN defined):
- Reset, then 4 writes 0xA1..0xA4 -> count 1,2,3,4; almost_empty drops after 2nd write; almost_full rises after 3rd; full after 4th; r_data=0xA1 throughout.
- From full, wr=1 rd=0 with 0xFF -> state unchanged, overflow=1. Then 4 reads -> r_data 0xA1,0xA2,0xA3,0xA4; empty=1 after 4th; 0xFF never appears.
- From full, wr=rd=1 with 0xB5 -> count stays 4, full stays 1, r_data advances to 0xA2. Draining then yields 0xA2,0xA3,0xA4,0xB5.
- From empty, wr=rd=1 with 0xC7 -> count=1, empty=0, r_data=0xC7, underflow=1. Then clr_err=1 for one cycle -> underflow=0, overflow=0.
- Wrap: 10 cycles alternating write/read (0x10..0x19) -> each read returns the matching word across the pointer wrap; count stays within 0..1.
- Write 3 words, assert RESET_N low asynchronously mid-cycle -> empty=1 and count=0 immediately. After release, write 0x55 -> r_data=0x55.
